start_fifo_srl_reader: RTL

- Read-side controller and complete wrapper for the SRL-based start-token FIFO that links one dataflow task's start to a downstream PE task.
- Owns the occupancy counter, the read address into the shift-register storage, and the full/empty flags.
- Exposes the HLS-style if_* write and read handshakes.
- Instantiates the SRL storage internally: shift on push, addressed read of the oldest entry.

---
 rtl/start_fifo_srl_reader.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/start_fifo_srl_reader.sv
// rtl/start_fifo_srl_reader.sv - SRL start-token FIFO: read-side control plus storage
//
// Purpose:
//   Links one dataflow task's start to a downstream PE task. The read-side
//   controller owns the occupancy counter, the read address into the
//   shift-register storage and the registered full/empty flags. The SRL storage
//   shifts on every accepted push. The oldest token is read out combinationally
//   from slot r_addr.
//
// Ports:
//   clk               in   rising-edge clock
//   reset_n           in   asynchronous active-low reset
//   if_write_ce       in   write-side clock enable
//   if_write          in   push request
//   if_din            in   token to push (DATA_WIDTH)
//   if_full_n         out  high while at least one slot is free
//   if_read_ce        in   read-side clock enable
//   if_read           in   pop request
//   if_dout           out  oldest token, valid while if_empty_n is high
//   if_empty_n        out  high while at least one token is stored
//   if_num_data_valid out  occupancy 0..DEPTH (ADDR_WIDTH+1)

module start_fifo_srl_reader_srl #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [DATA_WIDTH-1:0] o_dout
);

  // Storage is deliberately left unreset. The controller's flags are what
  // decide whether a slot holds a live token.
  logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (i_shift) begin
      for (int i = DEPTH - 1; i > 0; i--) begin
        r_mem[i] <= r_mem[i-1];
      end
      r_mem[0] <= i_din;
    end
  end

  assign o_dout = r_mem[i_addr];

endmodule

module start_fifo_srl_reader #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 1,
  parameter int DEPTH      = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   if_num_data_valid
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] LP_ADDR_ONE = ADDR_WIDTH'(1);

  logic [CW-1:0]         r_count;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_full_n;
  logic                  r_empty_n;

  logic                  w_push;
  logic                  w_pop;
  logic [CW-1:0]         w_count_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;

  // Qualification uses the registered flags only. As a result, neither if_read
  // nor if_write has a combinational path to the opposite flag.
  assign w_push = if_write_ce & if_write & r_full_n;
  assign w_pop  = if_read_ce & if_read & r_empty_n;

  always_comb begin
    w_count_nxt = r_count;
    w_addr_nxt  = r_addr;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + LP_CNT_ONE;
      // The first token lands in slot 0, which is already the read address.
      if (r_count != '0) begin
        w_addr_nxt = r_addr + LP_ADDR_ONE;
      end
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - LP_CNT_ONE;
      // Popping the last token leaves addr parked at 0 rather than wrapping.
      if (r_count != LP_CNT_ONE) begin
        w_addr_nxt = r_addr - LP_ADDR_ONE;
      end
    end
    // With push and pop together, the shift moves the oldest token up past
    // addr as it retires, so the count and addr stay as they are.
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count   <= '0;
      r_addr    <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
    end else begin
      r_count   <= w_count_nxt;
      r_addr    <= w_addr_nxt;
      r_full_n  <= (w_count_nxt != LP_DEPTH);
      r_empty_n <= (w_count_nxt != '0);
    end
  end

  start_fifo_srl_reader_srl #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk     (clk),
    .i_shift (w_push),
    .i_din   (if_din),
    .i_addr  (r_addr),
    .o_dout  (if_dout)
  );

  assign if_full_n         = r_full_n;
  assign if_empty_n        = r_empty_n;
  assign if_num_data_valid = r_count;

endmodule
